readwrite_register_bank: RTL and testbench

READWRITE_REGISTER_BANK -- requirements
Module: readwrite_register_bank

---
 rtl/readwrite_register_bank.sv | 201 ++++++++++++++++++++
 tb/tb_readwrite_register_bank.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/readwrite_register_bank.sv
// readwrite_register_bank: CPU-mapped bank of 32-bit registers
// with byte/half/word access, per-register peripheral writes and
// an optional change interrupt (macro REG_BANK_IRQ_EN).
// Ports:
//   clk, areset      clock, async active-high reset
//   i_hw_wr_en/data  per-register peripheral write strobe/data
//   o_registers      current contents, register i in slice i
//   i_req_*          addr/count/wr_en/wr_data request
//   o_res_rd_data    registered read data
//   o_res_code       registered response code
//   o_irq            change interrupt (0 without REG_BANK_IRQ_EN)

`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`endif
`ifndef MEM_CODE_INVALID
`define MEM_CODE_INVALID 3'd0
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`endif

module readwrite_register_bank #(
  parameter int unsigned ADDR_COUNT = 4,
  parameter int unsigned ADDR_START = 0,
  parameter logic [ADDR_COUNT-1:0] WR_MASK = '1,
  parameter logic [ADDR_COUNT*`WORD_W-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic [ADDR_COUNT-1:0]        i_hw_wr_en,
  input  logic [ADDR_COUNT*`WORD_W-1:0] i_hw_wr_data,
  output logic [ADDR_COUNT*`WORD_W-1:0] o_registers,
  input  logic [`ADDR_W-1:0]           i_req_addr,
  input  logic [`MEM_COUNT_W-1:0]      i_req_count,
  input  logic                         i_req_wr_en,
  input  logic [`WORD_W-1:0]           i_req_wr_data,
  output logic [`WORD_W-1:0]           o_res_rd_data,
  output logic [`MEM_CODE_W-1:0]       o_res_code,
  output logic                         o_irq
);

  localparam int IW = (ADDR_COUNT > 1) ? $clog2(ADDR_COUNT) : 1;
  localparam int XW = `ADDR_W - 2;

  logic [`WORD_W-1:0] r_regs [ADDR_COUNT];
  logic [`WORD_W-1:0] r_rd_data;
  logic [`MEM_CODE_W-1:0] r_code;

  logic [XW-1:0] w_idx;
  logic [XW-1:0] w_rel;
  logic [1:0] w_off;
  logic [IW-1:0] w_reg;
  logic w_busy;
  logic w_misal;
  logic w_inrange;
  logic w_valid;
  logic w_rd;
  logic w_wr_ok;
  logic [4:0] w_shamt;
  logic [`WORD_W-1:0] w_mask;
  logic [`WORD_W-1:0] w_cur;
  logic [`WORD_W-1:0] w_rdata;
  logic [`WORD_W-1:0] w_merged;
  logic [`MEM_CODE_W-1:0] w_code;
  logic [`WORD_W-1:0] w_data;

  assign w_idx = i_req_addr[`ADDR_W-1:2];
  assign w_off = i_req_addr[1:0];
  assign w_rel = w_idx - XW'(ADDR_START);
  assign w_reg = w_rel[IW-1:0];
  assign w_inrange = (w_idx >= XW'(ADDR_START)) &&
                     (w_rel < XW'(ADDR_COUNT));

  // Lane mask and shift amount for the access size;
  // read and write both work on the masked lane.
  always_comb begin
    w_mask  = '0;
    w_shamt = '0;
    w_misal = 1'b0;
    case (i_req_count)
      `MEM_COUNT_BYTE: begin
        w_shamt = {w_off, 3'b000};
        w_mask  = 32'h0000_00FF << w_shamt;
      end
      `MEM_COUNT_HALF: begin
        w_shamt = {w_off[1], 4'b0000};
        w_mask  = 32'h0000_FFFF << w_shamt;
        w_misal = w_off[0];
      end
      `MEM_COUNT_WORD: begin
        w_mask  = '1;
        w_misal = (w_off != 2'd0);
      end
      default: ;
    endcase
  end

  assign w_busy  = (i_req_count != `MEM_COUNT_NONE);
  assign w_valid = w_busy && !w_misal && w_inrange;
  assign w_rd    = w_valid && !i_req_wr_en;
  assign w_wr_ok = w_valid && i_req_wr_en && WR_MASK[w_reg];

  assign w_cur    = w_inrange ? r_regs[w_reg] : '0;
  assign w_rdata  = (w_cur & w_mask) >> w_shamt;
  assign w_merged = (w_cur & ~w_mask) |
                    ((i_req_wr_data << w_shamt) & w_mask);

  always_comb begin
    w_code = `MEM_CODE_INVALID;
    w_data = '0;
    if (w_busy && w_misal) begin
      w_code = `MEM_CODE_MISALIGNED;
    end else if (w_rd) begin
      w_code = `MEM_CODE_READ;
      w_data = w_rdata;
    end else if (w_wr_ok) begin
      w_code = `MEM_CODE_WRITE;
    end
  end

  // Peripheral write wins over a CPU write to the same register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < int'(ADDR_COUNT); i++)
        r_regs[i] <= RESET_VALUE[i*`WORD_W +: `WORD_W];
    end else begin
      for (int i = 0; i < int'(ADDR_COUNT); i++) begin
        if (i_hw_wr_en[i])
          r_regs[i] <= i_hw_wr_data[i*`WORD_W +: `WORD_W];
        else if (w_wr_ok && (w_reg == IW'(i)))
          r_regs[i] <= w_merged;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_code    <= `MEM_CODE_INVALID;
      r_rd_data <= '0;
    end else begin
      r_code    <= w_code;
      r_rd_data <= w_data;
    end
  end

  assign o_res_code    = r_code;
  assign o_res_rd_data = r_rd_data;

  always_comb begin
    o_registers = '0;
    for (int i = 0; i < int'(ADDR_COUNT); i++)
      o_registers[i*`WORD_W +: `WORD_W] = r_regs[i];
  end

`ifdef REG_BANK_IRQ_EN
  logic [ADDR_COUNT-1:0] r_flags;
  logic [ADDR_COUNT-1:0] w_flags_nx;
  logic r_irq;

  // Set (value change) beats clear (CPU read) in one cycle.
  always_comb begin
    w_flags_nx = '0;
    for (int i = 0; i < int'(ADDR_COUNT); i++)
      w_flags_nx[i] =
        (i_hw_wr_en[i] &&
         (i_hw_wr_data[i*`WORD_W +: `WORD_W] != r_regs[i])) ||
        (r_flags[i] && !(w_rd && (w_reg == IW'(i))));
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_flags <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_flags <= w_flags_nx;
      r_irq   <= |w_flags_nx;
    end
  end

  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_readwrite_register_bank.sv
// tb_readwrite_register_bank: directed + random checks of the
// register bank against a byte-level behavioural model.

`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`endif
`ifndef MEM_CODE_INVALID
`define MEM_CODE_INVALID 3'd0
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`endif

module tb_readwrite_register_bank;

  localparam int N = 4;
  localparam int START = 4;
  localparam logic [N-1:0] MASK = 4'b0111;
  localparam logic [N*32-1:0] RV = {
    32'h3333_0003, 32'h2222_0002,
    32'h1111_0001, 32'hCAFE_0000};
`ifdef REG_BANK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic areset = 1'b0;
  logic [N-1:0] i_hw_wr_en = '0;
  logic [N*32-1:0] i_hw_wr_data = '0;
  logic [N*32-1:0] o_registers;
  logic [31:0] i_req_addr = '0;
  logic [1:0] i_req_count = '0;
  logic i_req_wr_en = 1'b0;
  logic [31:0] i_req_wr_data = '0;
  logic [31:0] o_res_rd_data;
  logic [2:0] o_res_code;
  logic o_irq;

  int total = 0;
  int bad = 0;

  logic [31:0] m_regs [N];
  bit m_flags [N];
  logic [31:0] m_data;
  logic [2:0] m_code;

  readwrite_register_bank #(
    .ADDR_COUNT(N),
    .ADDR_START(START),
    .WR_MASK(MASK),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .areset(areset),
    .i_hw_wr_en(i_hw_wr_en),
    .i_hw_wr_data(i_hw_wr_data),
    .o_registers(o_registers),
    .i_req_addr(i_req_addr),
    .i_req_count(i_req_count),
    .i_req_wr_en(i_req_wr_en),
    .i_req_wr_data(i_req_wr_data),
    .o_res_rd_data(o_res_rd_data),
    .o_res_code(o_res_code),
    .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = RV[i*32 +: 32];
      m_flags[i] = 1'b0;
    end
    m_code = `MEM_CODE_INVALID;
    m_data = '0;
  endtask

  // One request plus peripheral writes, evaluated on the
  // pre-edge state, byte by byte.
  task automatic model_step(input logic [31:0] addr,
                            input logic [1:0] cnt,
                            input logic wr,
                            input logic [31:0] wd,
                            input logic [N-1:0] hwen,
                            input logic [N*32-1:0] hwd);
    logic [31:0] nxt [N];
    int unsigned idx;
    int unsigned off;
    int unsigned size;
    int unsigned r;
    nxt = m_regs;
    idx = addr >> 2;
    off = addr & 3;
    size = (cnt == 2'd1) ? 1 : (cnt == 2'd2) ? 2 :
           (cnt == 2'd3) ? 4 : 0;
    m_code = `MEM_CODE_INVALID;
    m_data = '0;
    if (size != 0) begin
      if (off % size != 0) begin
        m_code = `MEM_CODE_MISALIGNED;
      end else if (idx >= START && idx < START + N) begin
        r = idx - START;
        if (!wr) begin
          m_code = `MEM_CODE_READ;
          for (int b = 0; b < int'(size); b++)
            m_data[8*b +: 8] = m_regs[r][8*(int'(off)+b) +: 8];
          m_flags[r] = 1'b0;
        end else if (MASK[r]) begin
          m_code = `MEM_CODE_WRITE;
          for (int b = 0; b < int'(size); b++)
            nxt[r][8*(int'(off)+b) +: 8] = wd[8*b +: 8];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (hwen[i]) begin
        if (hwd[i*32 +: 32] != m_regs[i]) m_flags[i] = 1'b1;
        nxt[i] = hwd[i*32 +: 32];
      end
    end
    m_regs = nxt;
  endtask

  task automatic check_all();
    bit any;
    any = 1'b0;
    for (int i = 0; i < N; i++) any |= m_flags[i];
    chk("code", o_res_code, m_code);
    chk("rdata", o_res_rd_data, m_data);
    for (int i = 0; i < N; i++)
      chk($sformatf("reg%0d", i), o_registers[i*32 +: 32], m_regs[i]);
    chk("irq", o_irq, IRQ_ON & any);
  endtask

  task automatic step(input logic [31:0] addr,
                      input logic [1:0] cnt,
                      input logic wr,
                      input logic [31:0] wd,
                      input logic [N-1:0] hwen,
                      input logic [N*32-1:0] hwd);
    i_req_addr = addr;
    i_req_count = cnt;
    i_req_wr_en = wr;
    i_req_wr_data = wd;
    i_hw_wr_en = hwen;
    i_hw_wr_data = hwd;
    model_step(addr, cnt, wr, wd, hwen, hwd);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(32'h0, `MEM_COUNT_NONE, 1'b0, 32'h0, '0, '0);
  endtask

  initial begin
    logic [N-1:0] hwen;
    logic [N*32-1:0] hwd;
    model_reset();
    #1 areset = 1'b1;
    #1 check_all();
    @(posedge clk);
    #1 areset = 1'b0;

    // word read of register 0 at ADDR_START
    step(32'h10, `MEM_COUNT_WORD, 1'b0, 32'h0, '0, '0);
    chk("rd_rv0", o_res_rd_data, 32'hCAFE_0000);

    // word write, byte merge, word read back
    step(32'h14, `MEM_COUNT_WORD, 1'b1, 32'hAABB_CCDD, '0, '0);
    step(32'h16, `MEM_COUNT_BYTE, 1'b1, 32'h0000_0011, '0, '0);
    step(32'h14, `MEM_COUNT_WORD, 1'b0, 32'h0, '0, '0);
    chk("merge", o_res_rd_data, 32'hAA11_CCDD);

    // misaligned half, out-of-range word (both ends)
    step(32'h11, `MEM_COUNT_HALF, 1'b0, 32'h0, '0, '0);
    chk("misal", o_res_code, `MEM_CODE_MISALIGNED);
    step(32'h20, `MEM_COUNT_WORD, 1'b0, 32'h0, '0, '0);
    chk("oor_hi", o_res_code, `MEM_CODE_INVALID);
    step(32'h0C, `MEM_COUNT_WORD, 1'b1, 32'h1234, '0, '0);

    // hw write beats same-cycle CPU write
    hwd = '0;
    hwd[31:0] = 32'h5;
    step(32'h10, `MEM_COUNT_WORD, 1'b1, 32'h1, 4'b0001, hwd);
    chk("hw_prio", o_registers[31:0], 32'h5);
    chk("hw_code", o_res_code, `MEM_CODE_WRITE);

    // write to read-only register 3
    step(32'h1C, `MEM_COUNT_WORD, 1'b1, 32'hFFFF_FFFF, '0, '0);
    chk("ro_code", o_res_code, `MEM_CODE_INVALID);
    chk("ro_val", o_registers[127:96], 32'h3333_0003);

    // change interrupt on register 2
    step(32'h10, `MEM_COUNT_BYTE, 1'b0, 32'h0, '0, '0);
    step(32'h18, `MEM_COUNT_WORD, 1'b1, 32'h0, '0, '0);
    hwd = '0;
    hwd[95:64] = 32'h7;
    step(32'h0, `MEM_COUNT_NONE, 1'b0, 32'h0, 4'b0100, hwd);
    chk("irq_set", o_irq, IRQ_ON);
    step(32'h19, `MEM_COUNT_BYTE, 1'b0, 32'h0, '0, '0);
    chk("irq_clr", o_irq, 1'b0);
    step(32'h0, `MEM_COUNT_NONE, 1'b0, 32'h0, 4'b0100, hwd);
    chk("irq_same", o_irq, 1'b0);

    // reset between write request and its response
    i_req_addr = 32'h10;
    i_req_count = `MEM_COUNT_WORD;
    i_req_wr_en = 1'b1;
    i_req_wr_data = 32'hDEAD_BEEF;
    i_hw_wr_en = '0;
    #2 areset = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 areset = 1'b0;
    i_req_count = `MEM_COUNT_NONE;
    check_all();
    chk("rst_reg0", o_registers[31:0], 32'hCAFE_0000);
    idle();

    // random traffic
    repeat (3000) begin
      hwen = '0;
      hwd = '0;
      for (int i = 0; i < N; i++) begin
        hwen[i] = ($urandom_range(0, 7) == 0);
        hwd[i*32 +: 32] = $urandom_range(0, 1) ? m_regs[i]
                                              : $urandom;
      end
      step($urandom_range(0, 47), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom, hwen, hwd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
